// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the Alu: accepts one instruction, reads two
// source registers, drives the Alu operands, and writes the result back.
module alu_issue_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic [31:0]               instr,
   input  logic                      instrValid,
   output logic                      instrReady,
   output logic [REG_ADDR_WIDTH-1:0] rsAddr,
   output logic [REG_ADDR_WIDTH-1:0] rtAddr,
   input  logic [DATA_WIDTH-1:0]     rsData,
   input  logic [DATA_WIDTH-1:0]     rtData,
   output logic [DATA_WIDTH-1:0]     operand1,
   output logic [DATA_WIDTH-1:0]     operand2,
   output logic [5:0]                opCode,
   input  logic [DATA_WIDTH-1:0]     result,
   output logic                      wrEn,
   output logic [REG_ADDR_WIDTH-1:0] wrAddr,
   output logic [DATA_WIDTH-1:0]     wrData,
   output logic                      illegal,
   output logic [COUNT_WIDTH-1:0]    retireCount
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   typedef enum logic [5:0] {
      OP_ADD = 6'd0,
      OP_SUB = 6'd1,
      OP_AND = 6'd2,
      OP_OR  = 6'd3,
      OP_SLT = 6'd4
   } alu_op_t;

   state_t                    state_q, state_d;
   alu_op_t                   op_q, dec_op;
   logic                      imm_sel_q, dec_imm;
   logic                      dec_legal;
   logic [REG_ADDR_WIDTH-1:0] dec_dst;
   logic [REG_ADDR_WIDTH-1:0] rs_q, rt_q;
   logic [15:0]               imm_q;
   logic                      accept;

   assign instrReady = (state_q == S_IDLE);
   assign accept     = instrValid && instrReady;
   assign rsAddr     = rs_q;
   assign rtAddr     = rt_q;
   // Combinational so an asynchronous reset during WB removes the strobe at once.
   assign wrEn       = (state_q == S_WB) && (wrAddr != '0);

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      dec_legal = 1'b0;
      dec_op    = OP_ADD;
      dec_imm   = 1'b0;
      dec_dst   = REG_ADDR_WIDTH'(instr[15:11]);
      unique case (instr[31:26])
         6'h00: begin
            dec_legal = 1'b1;
            unique case (instr[5:0])
               6'h20:   dec_op = OP_ADD;
               6'h22:   dec_op = OP_SUB;
               6'h24:   dec_op = OP_AND;
               6'h25:   dec_op = OP_OR;
               6'h2A:   dec_op = OP_SLT;
               default: dec_legal = 1'b0;
            endcase
         end
         6'h08: begin
            dec_legal = 1'b1;
            dec_imm   = 1'b1;
            dec_dst   = REG_ADDR_WIDTH'(instr[20:16]);
         end
         default: dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept && dec_legal) state_d = S_READ;
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= S_IDLE;
         op_q        <= OP_ADD;
         imm_sel_q   <= 1'b0;
         rs_q        <= '0;
         rt_q        <= '0;
         imm_q       <= '0;
         wrAddr      <= '0;
         operand1    <= '0;
         operand2    <= '0;
         opCode      <= '0;
         wrData      <= '0;
         illegal     <= 1'b0;
         retireCount <= '0;
      end else begin
         state_q <= state_d;
         illegal <= accept && !dec_legal;
         if (accept && dec_legal) begin
            op_q      <= dec_op;
            imm_sel_q <= dec_imm;
            rs_q      <= REG_ADDR_WIDTH'(instr[25:21]);
            rt_q      <= REG_ADDR_WIDTH'(instr[20:16]);
            imm_q     <= instr[15:0];
            wrAddr    <= dec_dst;
         end
         // Operands and opcode change only on the READ->EXEC edge and hold otherwise.
         if (state_q == S_READ) begin
            operand1 <= rsData;
            operand2 <= imm_sel_q ? {{(DATA_WIDTH-16){imm_q[15]}}, imm_q} : rtData;
            opCode   <= op_q;
         end
         if (state_q == S_EXEC) wrData <= result;
         if (state_q == S_WB) retireCount <= retireCount + COUNT_WIDTH'(1);
      end
   end

endmodule
